// File: rtl/l2_cache_pkg.sv
// Shared L2 request definitions: PCI field widths, op codes and the packed request word.
// Used by the L2 arbiter mux and the request receiver, so both sides share one layout.
package l2_cache_pkg;

    localparam int STRAND_W  = 2;
    localparam int UNIT_W    = 2;
    localparam int OP_W      = 3;
    localparam int WAY_W     = 2;
    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 512;
    localparam int MASK_W    = 64;
    localparam int PCI_REQ_W = STRAND_W + UNIT_W + OP_W + WAY_W + ADDR_W + DATA_W + MASK_W;

    localparam logic [OP_W-1:0] OP_LOAD        = 3'd0;
    localparam logic [OP_W-1:0] OP_STORE       = 3'd1;
    localparam logic [OP_W-1:0] OP_FLUSH       = 3'd2;
    localparam logic [OP_W-1:0] OP_INVALIDATE  = 3'd3;
    localparam logic [OP_W-1:0] OP_IINVALIDATE = 3'd4;
    localparam logic [OP_W-1:0] OP_LOAD_SYNC   = 3'd5;
    localparam logic [OP_W-1:0] OP_STORE_SYNC  = 3'd6;

    typedef struct packed {
        logic [STRAND_W-1:0] strand;
        logic [UNIT_W-1:0]   unit;
        logic [OP_W-1:0]     op;
        logic [WAY_W-1:0]    way;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic [MASK_W-1:0]   mask;
    } l2_req_t;

endpackage

// File: rtl/l2_sync_fifo.sv
// Synchronous FIFO with registered count; head is read straight from storage (no bypass).
// Push and pop must be pre-qualified by the caller against full/empty.
module l2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry contents carry no reset so the wide array stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/l2_request_receiver.sv
// Captures PCI requests into a FIFO with a one-cycle registered ack; head is visible one cycle after accept.
// Full FIFO withholds ack until a slot frees; optional L2_RQ_STATS_EN adds accept/full-stall counters.
module l2_request_receiver
    import l2_cache_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pci_valid_i,
    output logic                     pci_ack_o,
    input  logic [STRAND_W-1:0]      pci_strand_i,
    input  logic [UNIT_W-1:0]        pci_unit_i,
    input  logic [OP_W-1:0]          pci_op_i,
    input  logic [WAY_W-1:0]         pci_way_i,
    input  logic [ADDR_W-1:0]        pci_address_i,
    input  logic [DATA_W-1:0]        pci_data_i,
    input  logic [MASK_W-1:0]        pci_mask_i,
    output logic                     rq_valid_o,
    input  logic                     rq_ready_i,
    output logic [STRAND_W-1:0]      rq_strand_o,
    output logic [UNIT_W-1:0]        rq_unit_o,
    output logic [OP_W-1:0]          rq_op_o,
    output logic [WAY_W-1:0]         rq_way_o,
    output logic [ADDR_W-1:0]        rq_address_o,
    output logic [DATA_W-1:0]        rq_data_o,
    output logic [MASK_W-1:0]        rq_mask_o,
    output logic [$clog2(DEPTH):0]   rq_count_o,
    output logic                     rq_almost_full_o
`ifdef L2_RQ_STATS_EN
    ,
    output logic [31:0]              stat_accepted_o,
    output logic [31:0]              stat_full_stall_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);

    l2_req_t req_in;
    l2_req_t req_head;
    logic    accept;
    logic    pop;

    assign req_in = '{
        strand:  pci_strand_i,
        unit:    pci_unit_i,
        op:      pci_op_i,
        way:     pci_way_i,
        address: pci_address_i,
        data:    pci_data_i,
        mask:    pci_mask_i
    };

    // The ack guard blocks a second capture if valid lingers high during the ack cycle.
    assign accept = pci_valid_i && !pci_ack_o && (rq_count_o < DEPTH_CNT);
    assign pop    = rq_valid_o && rq_ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pci_ack_o <= 1'b0;
        end else begin
            pci_ack_o <= accept;
        end
    end

    l2_sync_fifo #(
        .WIDTH (PCI_REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (req_in),
        .pop       (pop),
        .head_data (req_head),
        .count     (rq_count_o)
    );

    assign rq_valid_o       = (rq_count_o != '0);
    assign rq_almost_full_o = (rq_count_o >= AFULL_CNT);

    assign rq_strand_o  = req_head.strand;
    assign rq_unit_o    = req_head.unit;
    assign rq_op_o      = req_head.op;
    assign rq_way_o     = req_head.way;
    assign rq_address_o = req_head.address;
    assign rq_data_o    = req_head.data;
    assign rq_mask_o    = req_head.mask;

`ifdef L2_RQ_STATS_EN
    logic full_stall;

    assign full_stall = pci_valid_i && !pci_ack_o && (rq_count_o == DEPTH_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_accepted_o   <= '0;
            stat_full_stall_o <= '0;
        end else begin
            if (accept) begin
                stat_accepted_o <= stat_accepted_o + 32'd1;
            end
            if (full_stall) begin
                stat_full_stall_o <= stat_full_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_request_receiver.sv
// Directed + randomized bench for l2_request_receiver against a queue-based reference model.
module tb_l2_request_receiver;
    import l2_cache_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pci_valid;
    logic              pci_ack;
    logic              rq_ready;
    logic              rq_valid;
    logic [STRAND_W-1:0] rq_strand;
    logic [UNIT_W-1:0]   rq_unit;
    logic [OP_W-1:0]     rq_op;
    logic [WAY_W-1:0]    rq_way;
    logic [ADDR_W-1:0]   rq_address;
    logic [DATA_W-1:0]   rq_data;
    logic [MASK_W-1:0]   rq_mask;
    logic [CNT_W-1:0]    rq_count;
    logic                rq_afull;
`ifdef L2_RQ_STATS_EN
    logic [31:0]         stat_acc;
    logic [31:0]         stat_stall;
`endif

    l2_req_t cur;
    l2_req_t head;

    always #5 clk = ~clk;

    assign head = {rq_strand, rq_unit, rq_op, rq_way, rq_address, rq_data, rq_mask};

    l2_request_receiver #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pci_valid_i      (pci_valid),
        .pci_ack_o        (pci_ack),
        .pci_strand_i     (cur.strand),
        .pci_unit_i       (cur.unit),
        .pci_op_i         (cur.op),
        .pci_way_i        (cur.way),
        .pci_address_i    (cur.address),
        .pci_data_i       (cur.data),
        .pci_mask_i       (cur.mask),
        .rq_valid_o       (rq_valid),
        .rq_ready_i       (rq_ready),
        .rq_strand_o      (rq_strand),
        .rq_unit_o        (rq_unit),
        .rq_op_o          (rq_op),
        .rq_way_o         (rq_way),
        .rq_address_o     (rq_address),
        .rq_data_o        (rq_data),
        .rq_mask_o        (rq_mask),
        .rq_count_o       (rq_count),
        .rq_almost_full_o (rq_afull)
`ifdef L2_RQ_STATS_EN
        ,
        .stat_accepted_o   (stat_acc),
        .stat_full_stall_o (stat_stall)
`endif
    );

    // Reference model: ordered list of accepted requests plus the pending-ack flag.
    l2_req_t     q[$];
    bit          ack_m;
    int unsigned acc_m;
    int unsigned stall_m;
    int          errors = 0;
    int          checks = 0;
    int          ready_pct = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("pci_ack", pci_ack, ack_m);
        chk("rq_valid", rq_valid, q.size() != 0);
        chk("rq_count", rq_count, q.size());
        chk("rq_almost_full", rq_afull, q.size() >= DEPTH - 1);
        if (q.size() != 0) chk("head_entry", head, q[0]);
`ifdef L2_RQ_STATS_EN
        chk("stat_accepted", stat_acc, acc_m);
        chk("stat_full_stall", stat_stall, stall_m);
`endif
    endtask

    // One clock: inputs are stable across the edge, outputs checked 1ns after it.
    task automatic tick();
        bit acc, pop, stall;
        rq_ready = ($urandom_range(99) < ready_pct);
        acc   = pci_valid && !ack_m && (q.size() < DEPTH);
        stall = pci_valid && !ack_m && (q.size() == DEPTH);
        pop   = rq_ready && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(cur);
            acc_m++;
        end
        if (stall) stall_m++;
        ack_m = acc;
        check_outputs();
    endtask

    function automatic l2_req_t rand_req();
        l2_req_t r;
        logic [31:0] w;
        w = $urandom();
        r.strand  = w[1:0];
        r.unit    = w[3:2];
        r.op      = w[6:4];
        r.way     = w[8:7];
        w = $urandom();
        r.address = w[25:0];
        for (int i = 0; i < 16; i++) r.data[i*32 +: 32] = $urandom();
        r.mask = {$urandom(), $urandom()};
        return r;
    endfunction

    // Arbiter behaviour: hold valid until ack, then drop it (optionally glitching high during ack).
    task automatic send(input l2_req_t r, input bit glitch, input bit finish_ack, output int waited);
        cur = r;
        pci_valid = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!pci_ack && waited < 40);
        checks++;
        assert (pci_ack === 1'b1) else begin
            errors++;
            $error("FAIL ack_timeout observed=%0b expected=1", pci_ack);
        end
        pci_valid = glitch;
        if (finish_ack) begin
            tick();
            pci_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        pci_valid = 1'b0;
        ready_pct = 100;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        ready_pct = 0;
        chk("drain_empty", rq_valid, 1'b0);
    endtask

    initial begin
        int      w;
        l2_req_t r;

        reset_n   = 1'b0;
        pci_valid = 1'b0;
        rq_ready  = 1'b0;
        cur       = '0;
        ack_m     = 1'b0;
        acc_m     = 0;
        stall_m   = 0;
        @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        tick();

        // Single request: ack one cycle after valid, head visible with identical fields.
        r = rand_req();
        r.address = 26'h0000123;
        r.op      = 3'd2;
        r.mask    = '1;
        send(r, 1'b0, 1'b1, w);
        chk("single_ack_latency", w, 1);
        chk("single_head_addr", rq_address, 26'h0000123);
        chk("single_count", rq_count, 1);

        // Back-to-back up to full; one request glitches valid during its ack cycle.
        for (int i = 0; i < 3; i++) begin
            send(rand_req(), (i == 1), 1'b1, w);
            chk("b2b_ack_latency", w, 1);
        end
        chk("b2b_full_count", rq_count, DEPTH);

        // Full stall: held valid is not acked until a pop frees a slot, then acked next cycle.
        cur = rand_req();
        pci_valid = 1'b1;
        repeat (5) tick();
        ready_pct = 100;
        tick();
        ready_pct = 0;
        tick();
        chk("stall_release_ack", pci_ack, 1'b1);
        pci_valid = 1'b0;
        tick();
`ifdef L2_RQ_STATS_EN
        chk("stall_total", stat_stall, 6);
`endif

        // Bring count to 2, then push and pop in the same cycle.
        ready_pct = 100;
        tick();
        tick();
        chk("pre_simul_count", rq_count, 2);
        send(rand_req(), 1'b0, 1'b0, w);
        chk("simul_count", rq_count, 2);
        ready_pct = 0;
        pci_valid = 1'b0;
        tick();

        // Randomized-data stream with random consumer readiness.
        ready_pct = 50;
        for (int i = 0; i < 20; i++) send(rand_req(), $urandom_range(1) == 1, 1'b1, w);
        drain();

        // Pointer wrap: ten requests through a toggling consumer.
        for (int i = 0; i < 10; i++) begin
            ready_pct = (i % 2 == 0) ? 100 : 0;
            send(rand_req(), 1'b0, 1'b1, w);
        end
        drain();

        // Asynchronous reset with count=3 and ack high.
        send(rand_req(), 1'b0, 1'b1, w);
        send(rand_req(), 1'b0, 1'b1, w);
        send(rand_req(), 1'b0, 1'b0, w);
        chk("pre_reset_count", rq_count, 3);
        chk("pre_reset_ack", pci_ack, 1'b1);
        #2;
        reset_n = 1'b0;
        pci_valid = 1'b0;
        #1;
        chk("async_reset_ack", pci_ack, 1'b0);
        chk("async_reset_valid", rq_valid, 1'b0);
        chk("async_reset_count", rq_count, 0);
        q.delete();
        ack_m   = 1'b0;
        acc_m   = 0;
        stall_m = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        send(rand_req(), 1'b0, 1'b1, w);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
